// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the registered N-way Wishbone bridge.
package wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   // Index wide enough for the largest supported port count.
   localparam int MAX_PORTS  = 8;
   localparam int PORT_IDX_W = $clog2(MAX_PORTS);

   localparam logic [31:0] DEF_ERR_DATA = 32'hdead_beef;

endpackage

// File: rtl/wb_bridge_decode.sv
// Window hit, port selection and local address translation.
module wb_bridge_decode
   import wb_bridge_pkg::*;
#(
   parameter int NUM_PORTS       = 4,
   parameter int PORT_ADDR_WIDTH = 24
) (
   input  logic [31:0]                adr,
   input  logic [31:0]                base,
   input  logic [31:0]                mask,
   input  logic [NUM_PORTS*32-1:0]    offsets,
   output logic                       hit,
   output logic                       mapped,
   output logic [PORT_IDX_W-1:0]      port,
   output logic [PORT_ADDR_WIDTH-1:0] xadr
);

   logic [31:0] loc;
   logic [31:0] sub;

   always_comb begin
      loc    = adr & ~mask;
      hit    = (adr & mask) == base;
      mapped = loc >= offsets[31:0];
      port   = '0;
      sub    = loc - offsets[31:0];
      // Offsets ascend, so the last match is the highest qualifying port.
      for (int i = 1; i < NUM_PORTS; i++) begin
         if (loc >= offsets[i*32 +: 32]) begin
            port = PORT_IDX_W'(i);
            sub  = loc - offsets[i*32 +: 32];
         end
      end
      xadr = PORT_ADDR_WIDTH'(sub);
   end

endmodule

// File: rtl/wb_bridge_nway.sv
// Registered N-way Wishbone classic bridge with timeout,
// unmapped-address error and upstream abort.
module wb_bridge_nway
   import wb_bridge_pkg::*;
#(
   parameter int                      NUM_PORTS       = 4,
   parameter logic [31:0]             UFP_BASE_ADDR   = 32'h3000_0000,
   parameter logic [31:0]             UFP_BASE_MASK   = 32'hff00_0000,
   parameter logic [NUM_PORTS*32-1:0] PORT_OFFSETS    = {32'h00ff_ffc0,
                                                         32'h0080_0000,
                                                         32'h0001_0000,
                                                         32'h0},
   parameter int                      PORT_ADDR_WIDTH = 24,
   parameter int                      TIMEOUT_CYCLES  = 255,
   parameter logic [31:0]             ERR_DATA        = DEF_ERR_DATA
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_ni,
   input  logic                       wbs_stb_i,
   input  logic                       wbs_cyc_i,
   input  logic                       wbs_we_i,
   input  logic [3:0]                 wbs_sel_i,
   input  logic [31:0]                wbs_dat_i,
   input  logic [31:0]                wbs_adr_i,
   output logic                       wbs_ack_o,
   output logic                       wbs_err_o,
   output logic [31:0]                wbs_dat_o,
   output logic [NUM_PORTS-1:0]       wbm_stb_o,
   output logic [NUM_PORTS-1:0]       wbm_cyc_o,
   output logic                       wbm_we_o,
   output logic [3:0]                 wbm_sel_o,
   output logic [PORT_ADDR_WIDTH-1:0] wbm_adr_o,
   output logic [31:0]                wbm_dat_o,
   input  logic [NUM_PORTS-1:0]       wbm_ack_i,
   input  logic [NUM_PORTS*32-1:0]    wbm_dat_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       err_q, err_d;
   logic [31:0]                rdat_q, rdat_d;
   logic [PORT_IDX_W-1:0]      port_q;
   logic                       lat;

   logic                       hit, mapped;
   logic [PORT_IDX_W-1:0]      dport;
   logic [PORT_ADDR_WIDTH-1:0] dadr;
   logic                       req, ack_sel, tmo;
   logic [NUM_PORTS-1:0]       oh;
   logic [31:0]                rd_sel;

   wb_bridge_decode #(
      .NUM_PORTS       (NUM_PORTS),
      .PORT_ADDR_WIDTH (PORT_ADDR_WIDTH)
   ) u_decode (
      .adr     (wbs_adr_i),
      .base    (UFP_BASE_ADDR),
      .mask    (UFP_BASE_MASK),
      .offsets (PORT_OFFSETS),
      .hit     (hit),
      .mapped  (mapped),
      .port    (dport),
      .xadr    (dadr)
   );

   assign req     = wbs_cyc_i & wbs_stb_i & hit;
   assign oh      = (state_q == BUSY) ? (NUM_PORTS'(1) << port_q) : '0;
   assign ack_sel = |(wbm_ack_i & oh);
   assign tmo     = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

   assign wbm_stb_o = oh;
   assign wbm_cyc_o = oh;
   assign wbs_ack_o = (state_q == RESP) & ~err_q;
   assign wbs_err_o = (state_q == RESP) & err_q;
   assign wbs_dat_o = rdat_q;

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (port_q == PORT_IDX_W'(i)) rd_sel = wbm_dat_i[i*32 +: 32];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdat_d  = rdat_q;
      lat     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               lat = 1'b1;
               if (!mapped) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdat_d  = ERR_DATA;
               end else begin
                  state_d = BUSY;
                  err_d   = 1'b0;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // Abort beats ack; ack beats timeout.
            if (!wbs_cyc_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (ack_sel) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdat_d  = wbm_we_o ? 32'h0 : rd_sel;
            end else if (tmo) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdat_d  = ERR_DATA;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         rdat_q    <= '0;
         port_q    <= '0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
         if (lat) begin
            port_q    <= dport;
            wbm_we_o  <= wbs_we_i;
            wbm_sel_o <= wbs_sel_i;
            wbm_adr_o <= dadr;
            wbm_dat_o <= wbs_dat_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Randomized and directed bench for wb_bridge_nway against a
// transaction-level reference model.
module tb_wb_bridge_nway;

   localparam int TMO = 8;

   logic         clk;
   logic         rst_n;
   logic         cyc, stb, we;
   logic [3:0]   sel;
   logic [31:0]  dati, adr;
   logic         ack_o, err_o;
   logic [31:0]  dato;
   logic [3:0]   mstb, mcyc;
   logic         mwe;
   logic [3:0]   msel;
   logic [23:0]  madr;
   logic [31:0]  mdat;
   logic [3:0]   mack;
   logic [127:0] mdati;

   logic         cyc_u, stb_u;
   logic         ack_u, err_u;
   logic [31:0]  dato_u;
   logic [3:0]   mstb_u, mcyc_u;
   logic         mwe_u;
   logic [3:0]   msel_u;
   logic [23:0]  madr_u;
   logic [31:0]  mdat_u;
   logic [3:0]   mack_u;
   logic [127:0] mdati_u;

   int total = 0;
   int bad   = 0;

   logic [31:0] off [4] = '{32'h0, 32'h0001_0000,
                            32'h0080_0000, 32'h00ff_ffc0};

   wb_bridge_nway #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dati),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack_o),
      .wbs_err_o (err_o),
      .wbs_dat_o (dato),
      .wbm_stb_o (mstb),
      .wbm_cyc_o (mcyc),
      .wbm_we_o  (mwe),
      .wbm_sel_o (msel),
      .wbm_adr_o (madr),
      .wbm_dat_o (mdat),
      .wbm_ack_i (mack),
      .wbm_dat_i (mdati)
   );

   wb_bridge_nway #(
      .PORT_OFFSETS   ({32'h00ff_ffc0, 32'h0080_0000,
                        32'h0001_0000, 32'h0000_0100}),
      .TIMEOUT_CYCLES (TMO)
   ) dut_u (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_stb_i (stb_u),
      .wbs_cyc_i (cyc_u),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dati),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack_u),
      .wbs_err_o (err_u),
      .wbs_dat_o (dato_u),
      .wbm_stb_o (mstb_u),
      .wbm_cyc_o (mcyc_u),
      .wbm_we_o  (mwe_u),
      .wbm_sel_o (msel_u),
      .wbm_adr_o (madr_u),
      .wbm_dat_o (mdat_u),
      .wbm_ack_i (mack_u),
      .wbm_dat_i (mdati_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Full transfer; ack_at is the BUSY cycle in which the slave acks
   // (0 = never). Expectations come from the address map and timeout rule.
   task automatic xfer(input logic [31:0] a, input logic w,
                       input logic [3:0] s, input logic [31:0] d,
                       input int ack_at, input logic [31:0] rd);
      logic [31:0] loc;
      logic [31:0] ea;
      logic [3:0]  ohp;
      logic [31:0] exp_data;
      int          p, exp_cyc;
      bit          exp_err, got;
      loc = a & 32'h00ff_ffff;
      p = 0;
      for (int i = 0; i < 4; i++) if (loc >= off[i]) p = i;
      ea       = loc - off[p];
      ohp      = 4'(1 << p);
      exp_err  = (ack_at < 1) || (ack_at > TMO);
      exp_cyc  = exp_err ? TMO + 1 : ack_at + 1;
      exp_data = exp_err ? 32'hdead_beef : (w ? 32'h0 : rd);
      for (int i = 0; i < 4; i++) mdati[i*32 +: 32] = $urandom;
      mdati[p*32 +: 32] = rd;
      mack = '0;
      adr = a; we = w; sel = s; dati = d;
      cyc = 1'b1; stb = 1'b1;
      got = 0;
      for (int b = 1; b <= TMO + 3 && !got; b++) begin
         @(posedge clk); #1;
         if (ack_o || err_o) begin
            got = 1;
            chk("resp_cycle", b, exp_cyc);
            chk("ack", ack_o, !exp_err);
            chk("err", err_o, exp_err);
            chk("rdata", dato, exp_data);
            chk("stb_in_resp", mstb, 4'h0);
            cyc = 1'b0; stb = 1'b0; mack = '0;
         end else begin
            chk("stb_busy", mstb, ohp);
            if (b == 1) begin
               chk("cyc_busy", mcyc, ohp);
               chk("m_adr", madr, ea[23:0]);
               chk("m_we", mwe, w);
               chk("m_sel", msel, s);
               chk("m_dat", mdat, d);
            end
            mack = 4'($urandom) & ~ohp;
            if (b == ack_at) mack[p] = 1'b1;
         end
      end
      chk("resp_seen", got, 1'b1);
      cyc = 1'b0; stb = 1'b0; mack = '0;
      @(posedge clk); #1;
      chk("pulse_end", {ack_o, err_o}, 2'b00);
      chk("idle_stb", mstb, 4'h0);
   endtask

   initial begin
      logic [31:0] loc, a;
      int          m, i;
      rst_n = 1'b0;
      cyc = 0; stb = 0; we = 0; sel = 0; dati = 0; adr = 0;
      mack = 0; mdati = 0;
      cyc_u = 0; stb_u = 0; mack_u = 0; mdati_u = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out", {ack_o, err_o, dato, mstb, mcyc, mwe,
                        msel, madr, mdat}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      xfer(32'h3000_0010, 1'b0, 4'hf, 32'h0, 2, 32'h1234_5678);
      xfer(32'h30ff_ffc4, 1'b1, 4'b0011, 32'ha5a5_a5a5, 1, 32'h5555_0000);
      xfer(32'h3001_0000, 1'b0, 4'hf, 32'h0, 0, 32'h1111_2222);
      xfer(32'h3001_0000, 1'b0, 4'hf, 32'h0, TMO, 32'h3333_4444);
      xfer(32'h3000_ffff, 1'b0, 4'hf, 32'h0, 1, 32'h0000_ffff);
      xfer(32'h30ff_ffbf, 1'b0, 4'hf, 32'h0, 3, 32'hbfbf_bfbf);
      xfer(32'h30ff_ffc0, 1'b1, 4'h8, 32'hc0c0_c0c0, 9, 32'h0);

      // Upstream abort in BUSY cycle 3.
      adr = 32'h3080_0020; we = 0; cyc = 1; stb = 1; mack = 0;
      for (int b = 1; b <= 3; b++) begin
         @(posedge clk); #1;
         chk("abort_stb", mstb, 4'b0100);
      end
      cyc = 0; stb = 0;
      for (int b = 0; b < 3; b++) begin
         @(posedge clk); #1;
         chk("abort_down", mstb, 4'h0);
         chk("abort_resp", {ack_o, err_o}, 2'b00);
      end

      // Address outside the window.
      adr = 32'h2000_0000; cyc = 1; stb = 1;
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         chk("miss_stb", mstb, 4'h0);
         chk("miss_resp", {ack_o, err_o}, 2'b00);
      end
      cyc = 0; stb = 0;
      @(posedge clk); #1;

      // Reset in the middle of BUSY.
      adr = 32'h3001_0008; cyc = 1; stb = 1;
      @(posedge clk); #1;
      chk("rst_busy_stb", mstb, 4'b0010);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", {ack_o, err_o, dato, mstb, mcyc, mwe,
                        msel, madr, mdat}, '0);
      cyc = 0; stb = 0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_no_resp", {ack_o, err_o}, 2'b00);
      xfer(32'h3001_0008, 1'b0, 4'hf, 32'h0, 4, 32'hcafe_f00d);

      // Unmapped region below the first port offset.
      adr = 32'h3000_0004; cyc_u = 1; stb_u = 1;
      @(posedge clk); #1;
      chk("unm_err", err_u, 1'b1);
      chk("unm_ack", ack_u, 1'b0);
      chk("unm_dat", dato_u, 32'hdead_beef);
      chk("unm_stb", mstb_u, 4'h0);
      cyc_u = 0; stb_u = 0;
      @(posedge clk); #1;
      chk("unm_end", {ack_u, err_u}, 2'b00);
      adr = 32'h3000_0104; cyc_u = 1; stb_u = 1;
      @(posedge clk); #1;
      chk("u_first_stb", mstb_u, 4'b0001);
      chk("u_first_adr", madr_u, 24'h4);
      cyc_u = 0; stb_u = 0;
      @(posedge clk); #1;
      chk("u_abort", mstb_u, 4'h0);

      for (int n = 0; n < 40; n++) begin
         m = $urandom_range(0, 2);
         i = $urandom_range(0, 3);
         case (m)
            0:       loc = $urandom & 32'h00ff_ffff;
            1:       loc = off[i];
            default: loc = (i == 0) ? 32'h0 : off[i] - 1;
         endcase
         a = 32'h3000_0000 | loc;
         xfer(a, 1'($urandom), 4'($urandom), $urandom,
              $urandom_range(0, TMO + 2), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
